// File: rtl/lvmb_adc_emu_pkg.sv
// Shared definitions for the LVMB MAX1271-style ADC responder emulation.
// Covers the FSM state encoding and the control-byte field positions.
package lvmb_adc_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CTRL,
    ST_CONV,
    ST_SHIFT
  } adc_state_e;

  // Control byte layout: [7] START, [6:4] SEL, [3] RNG, [2] BIP, [1:0] PD
  localparam int CTRL_BITS    = 8;
  localparam int CTRL_SEL_MSB = 6;
  localparam int CTRL_SEL_LSB = 4;

endpackage

// File: rtl/lvmb_adc_emu_sclk_sync.sv
// Synchronises the asynchronous ADC link pins into the clk domain.
// Also generates single-clk rise/fall pulses for the serial clock.
module lvmb_adc_emu_sclk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ce,
  input  logic i_sclk,
  input  logic i_sdi,
  output logic o_ce,
  output logic o_sdi,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);

  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk;

  // ce resets high so a link held in reset looks deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_sync   <= '1;
      r_sclk_sync <= '0;
      r_sdi_sync  <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_ce_sync   <= {r_ce_sync[SYNC_STAGES-2:0], i_ce};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign o_ce        = r_ce_sync[SYNC_STAGES-1];
  assign o_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk & ~r_sclk_prev;
  assign o_sclk_fall = ~w_sclk & r_sclk_prev;

endmodule

// File: rtl/lvmb_adc_emu.sv
// Responder end of one LVMB serial ADC link: decodes the control byte and
// streams the selected channel's snapshotted value back MSB first.
module lvmb_adc_emu
  import lvmb_adc_emu_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int DATA_W      = 12,
  parameter int CONV_SCLKS  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adc_ce,
  input  logic                  adc_sclk,
  input  logic                  adc_sdi,
  input  logic [NCH*DATA_W-1:0] ch_data,
  output logic                  adc_sdo,
  output logic [7:0]            ctrl_byte,
  output logic                  ctrl_valid,
  output logic                  busy
);

  localparam int DCNT_W = $clog2(DATA_W + 1);
  localparam int CCNT_W = (CONV_SCLKS > 1) ? $clog2(CONV_SCLKS + 1) : 1;

  logic              w_ce;
  logic              w_sdi;
  logic              w_rise;
  logic              w_fall;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_sel_data;

  adc_state_e        r_state, w_state_n;
  logic [3:0]        r_bit_cnt, w_bit_cnt_n;
  logic [6:0]        r_shreg, w_shreg_n;
  logic [DATA_W-1:0] r_out_reg, w_out_reg_n;
  logic [CCNT_W-1:0] r_conv_cnt, w_conv_cnt_n;
  logic [DCNT_W-1:0] r_data_cnt, w_data_cnt_n;
  logic              r_sdo, w_sdo_n;
  logic [7:0]        r_ctrl_byte, w_ctrl_byte_n;
  logic              r_ctrl_valid, w_ctrl_valid_n;

  lvmb_adc_emu_sclk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ce       (adc_ce),
    .i_sclk     (adc_sclk),
    .i_sdi      (adc_sdi),
    .o_ce       (w_ce),
    .o_sdi      (w_sdi),
    .o_sclk_rise(w_rise),
    .o_sclk_fall(w_fall)
  );

  // Byte as it stands once the current sdi bit is shifted in
  assign w_byte = {r_shreg, w_sdi};

  always_comb begin
    w_sel_data = '0;
    for (int n = 0; n < NCH; n++) begin
      if (int'(w_byte[CTRL_SEL_MSB:CTRL_SEL_LSB]) == n) begin
        w_sel_data = ch_data[n*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_bit_cnt_n    = r_bit_cnt;
    w_shreg_n      = r_shreg;
    w_out_reg_n    = r_out_reg;
    w_conv_cnt_n   = r_conv_cnt;
    w_data_cnt_n   = r_data_cnt;
    w_sdo_n        = r_sdo;
    w_ctrl_byte_n  = r_ctrl_byte;
    w_ctrl_valid_n = 1'b0;

    // Deselect overrides any serial clock edge seen in the same cycle
    if (w_ce) begin
      w_state_n = ST_IDLE;
      w_sdo_n   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_WAIT_START;
          w_sdo_n   = 1'b0;
        end
        ST_WAIT_START: begin
          if (w_rise && w_sdi) begin
            w_state_n   = ST_CTRL;
            w_bit_cnt_n = 4'd1;
            w_shreg_n   = 7'h01;
          end
        end
        ST_CTRL: begin
          if (w_rise) begin
            w_shreg_n   = w_byte[6:0];
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'(CTRL_BITS - 1)) begin
              w_ctrl_byte_n  = w_byte;
              w_ctrl_valid_n = 1'b1;
              w_out_reg_n    = w_sel_data;
              w_conv_cnt_n   = '0;
              w_state_n      = ST_CONV;
            end
          end
        end
        ST_CONV: begin
          if (w_rise) begin
            if (r_conv_cnt == CCNT_W'(CONV_SCLKS - 1)) begin
              w_state_n    = ST_SHIFT;
              w_data_cnt_n = '0;
            end else begin
              w_conv_cnt_n = r_conv_cnt + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (w_fall) begin
            w_sdo_n     = r_out_reg[DATA_W-1];
            w_out_reg_n = {r_out_reg[DATA_W-2:0], 1'b0};
            if (r_data_cnt != DCNT_W'(DATA_W)) begin
              w_data_cnt_n = r_data_cnt + 1'b1;
            end
          end else if (w_rise && w_sdi && (r_data_cnt == DCNT_W'(DATA_W))) begin
            w_state_n   = ST_CTRL;
            w_bit_cnt_n = 4'd1;
            w_shreg_n   = 7'h01;
            w_sdo_n     = 1'b0;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_sdo_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_out_reg    <= '0;
      r_conv_cnt   <= '0;
      r_data_cnt   <= '0;
      r_sdo        <= 1'b0;
      r_ctrl_byte  <= 8'h00;
      r_ctrl_valid <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_bit_cnt    <= w_bit_cnt_n;
      r_shreg      <= w_shreg_n;
      r_out_reg    <= w_out_reg_n;
      r_conv_cnt   <= w_conv_cnt_n;
      r_data_cnt   <= w_data_cnt_n;
      r_sdo        <= w_sdo_n;
      r_ctrl_byte  <= w_ctrl_byte_n;
      r_ctrl_valid <= w_ctrl_valid_n;
    end
  end

  assign adc_sdo    = r_sdo;
  assign ctrl_byte  = r_ctrl_byte;
  assign ctrl_valid = r_ctrl_valid;
  assign busy       = (r_state == ST_CTRL) || (r_state == ST_CONV) || (r_state == ST_SHIFT);

endmodule

// File: tb/tb_lvmb_adc_emu.sv
// Bench for lvmb_adc_emu: a bit-banged master drives directed frames while
// scoreboard queues hold the expected sdo bits and control bytes.
module tb_lvmb_adc_emu;

  localparam int NCH    = 8;
  localparam int DATA_W = 12;
  localparam int HALF   = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  adcCe = 1'b1;
  logic                  adcSclk = 1'b0;
  logic                  adcSdi = 1'b0;
  logic [NCH*DATA_W-1:0] chData = '0;
  logic                  adcSdo;
  logic [7:0]            ctrlByte;
  logic                  ctrlValid;
  logic                  busy;

  int         total = 0;
  int         bad = 0;
  bit         sdoQ[$];
  logic [7:0] ctrlQ[$];
  bit         expBit;
  logic [7:0] expByte;

  always #5 clk = ~clk;

  lvmb_adc_emu #(
    .NCH(NCH),
    .DATA_W(DATA_W),
    .CONV_SCLKS(1),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_ce    (adcCe),
    .adc_sclk  (adcSclk),
    .adc_sdi   (adcSdi),
    .ch_data   (chData),
    .adc_sdo   (adcSdo),
    .ctrl_byte (ctrlByte),
    .ctrl_valid(ctrlValid),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // The master samples sdo on its own rising edge, well after the DUT has
  // reacted to the preceding falling edge.
  always @(posedge adcSclk) begin
    if (sdoQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL sdo_unexpected_edge: got edge, expected none queued");
    end else begin
      expBit = sdoQ.pop_front();
      checkOutput("sdo_bit", 32'(adcSdo), 32'(expBit));
    end
  end

  always @(negedge clk) begin
    if (ctrlValid === 1'b1) begin
      if (ctrlQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL ctrl_valid_unexpected: got byte %0h, expected no pulse", ctrlByte);
      end else begin
        expByte = ctrlQ.pop_front();
        checkOutput("ctrl_byte", 32'(ctrlByte), 32'(expByte));
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclkCycle(input bit sdiVal, input bit expSdo);
    sdoQ.push_back(expSdo);
    adcSdi = sdiVal;
    waitClk(HALF);
    adcSclk = 1'b1;
    waitClk(HALF);
    adcSclk = 1'b0;
  endtask

  task automatic ceLow();
    adcCe = 1'b0;
    waitClk(8);
  endtask

  task automatic ceHigh();
    waitClk(4);
    adcCe = 1'b1;
    waitClk(8);
  endtask

  task automatic applyStimulus(input logic [7:0] ctrl, input int leadZeros,
                               input logic [11:0] expData, input bit corrupt, input int corruptCh);
    for (int i = 0; i < leadZeros; i++) sclkCycle(1'b0, 1'b0);
    ctrlQ.push_back(ctrl);
    for (int i = 7; i >= 0; i--) sclkCycle(ctrl[i], 1'b0);
    sclkCycle(1'b0, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      sclkCycle(1'b0, expData[DATA_W-1-i]);
      if (corrupt && i == 3) chData[corruptCh*DATA_W +: DATA_W] = ~chData[corruptCh*DATA_W +: DATA_W];
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    chData[0*DATA_W +: DATA_W] = 12'hFFF;
    chData[1*DATA_W +: DATA_W] = 12'h123;
    chData[2*DATA_W +: DATA_W] = 12'h9B7;
    chData[3*DATA_W +: DATA_W] = 12'hA5C;
    chData[4*DATA_W +: DATA_W] = 12'h444;
    chData[5*DATA_W +: DATA_W] = 12'h555;
    chData[6*DATA_W +: DATA_W] = 12'h666;
    chData[7*DATA_W +: DATA_W] = 12'h3C6;

    waitClk(3);
    checkOutput("rst_sdo", 32'(adcSdo), 32'd0);
    checkOutput("rst_ctrl_byte", 32'(ctrlByte), 32'h00);
    checkOutput("rst_ctrl_valid", 32'(ctrlValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    waitClk(4);

    // Plain read of channel 3, then zero fill after the 12 bits
    ceLow();
    applyStimulus(8'hB1, 0, 12'hA5C, 1'b0, 0);
    sclkCycle(1'b0, 1'b0);
    checkOutput("busy_shift", 32'(busy), 32'd1);
    ceHigh();
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("ctrlq_empty_t1", 32'(ctrlQ.size()), 32'd0);

    // Leading zeros before the start bit
    ceLow();
    applyStimulus(8'h81, 3, 12'hFFF, 1'b0, 0);
    sclkCycle(1'b0, 1'b0);
    ceHigh();

    // Abort after five control bits, then a clean read of channel 7
    ceLow();
    sclkCycle(1'b1, 1'b0);
    sclkCycle(1'b0, 1'b0);
    sclkCycle(1'b1, 1'b0);
    sclkCycle(1'b1, 1'b0);
    sclkCycle(1'b0, 1'b0);
    adcCe = 1'b1;
    waitClk(6);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sdo", 32'(adcSdo), 32'd0);
    checkOutput("abort_ctrl_byte", 32'(ctrlByte), 32'h81);
    waitClk(8);
    ceLow();
    applyStimulus(8'hF1, 0, 12'h3C6, 1'b0, 0);
    sclkCycle(1'b0, 1'b0);
    ceHigh();

    // Channel 3 changes mid-stream; the next read sees the new value
    ceLow();
    applyStimulus(8'hB1, 0, 12'hA5C, 1'b1, 3);
    sclkCycle(1'b0, 1'b0);
    ceHigh();
    ceLow();
    applyStimulus(8'hB1, 0, 12'h5A3, 1'b0, 0);
    sclkCycle(1'b0, 1'b0);
    ceHigh();

    // Two conversions in one chip-enable frame
    ceLow();
    applyStimulus(8'h91, 0, 12'h123, 1'b0, 0);
    applyStimulus(8'hA1, 0, 12'h9B7, 1'b0, 0);
    sclkCycle(1'b0, 1'b0);
    ceHigh();
    checkOutput("ctrlq_empty_t5", 32'(ctrlQ.size()), 32'd0);

    // Reset in the middle of shifting out channel 0
    ceLow();
    ctrlQ.push_back(8'h81);
    for (int i = 7; i >= 0; i--) sclkCycle(i == 7 || i == 0, 1'b0);
    sclkCycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sclkCycle(1'b0, 1'b1);
    waitClk(4);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    checkOutput("pre_rst_sdo", 32'(adcSdo), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sdo", 32'(adcSdo), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ctrl_byte", 32'(ctrlByte), 32'h00);
    waitClk(2);
    adcCe = 1'b1;
    rst_n = 1'b1;
    waitClk(8);

    ceLow();
    applyStimulus(8'hA1, 0, 12'h9B7, 1'b0, 0);
    sclkCycle(1'b0, 1'b0);
    ceHigh();

    checkOutput("sdoq_empty", 32'(sdoQ.size()), 32'd0);
    checkOutput("ctrlq_empty", 32'(ctrlQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
